outgoing_ar_arb_buffer: RTL and testbench
=========================================

OUTGOING_AR_ARB_BUFFER -- requirements
Module: outgoing_ar_arb_buffer

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 2, number of AR request sources (>=2).
REQ-002 The block SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-004 The block SHALL have parameter LEN_WIDTH, default 8, burst length width.
REQ-005 The block SHALL have parameter TAG_WIDTH, default 4, internal tag width.
REQ-006 The block SHALL have parameter FIFO_DEPTH, default 4, entries per source FIFO (power of two, >=2).
REQ-007 The block SHALL have parameter MAX_OUTSTANDING, default 8, maximum issued-but-uncompleted requests (>=1).
REQ-008 The block SHALL have parameter QOS_MODE, default 0: 0 = pure round-robin, 1 = highest-QoS-first.
REQ-009 The block SHALL have a single clock and an asynchronous active-high reset, as follows: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-010 in_valid input NUM_SRC; in_ready output NUM_SRC: per-source AR handshake.
REQ-011 in_id/in_addr/in_len/in_size/in_burst/in_qos/in_tagid inputs NUM_SRC*{ID_WIDTH,ADDR_WIDTH,LEN_WIDTH,3,2,4,TAG_WIDTH}, source i in slice i.
REQ-012 m_valid output 1; m_ready input 1; m_id/m_addr/m_len/m_size/m_burst/m_qos/m_tagid outputs of single-source widths: AR to slave.
REQ-013 m_src output $clog2(NUM_SRC): index of source that produced the current m_* request.
REQ-014 done_valid input 1: one-cycle pulse per completed read burst; inflight output $clog2(MAX_OUTSTANDING+1): current issued count; err_underflow output 1: sticky error flag.

Function
REQ-015 Each source SHALL own a FIFO of FIFO_DEPTH entries; in_ready[i] = not full[i], depending only on registered state.
REQ-016 Push on source i SHALL occur when in_valid[i] & in_ready[i]; simultaneous push and pop on one FIFO leaves its count unchanged.
REQ-017 There SHALL be no bypass: a request accepted at edge N is visible on m_* no earlier than after edge N+1.
REQ-018 Output register SHALL load when can_load = (~m_valid | m_ready) & any FIFO non-empty & inflight < MAX_OUTSTANDING; the load pops the winner's FIFO head.
REQ-019 While m_valid & ~m_ready, all m_* and m_src SHALL stay stable.
REQ-020 On m_valid & m_ready with no load, m_valid SHALL clear at that edge; with a load, m_valid stays 1 with the new request (back-to-back).
REQ-021 QOS_MODE=0: winner SHALL be the first non-empty source at or after rr_ptr (wrapping); after each grant rr_ptr = winner+1 mod NUM_SRC.
REQ-022 QOS_MODE=1: winner SHALL be the non-empty source with the highest head in_qos; ties are resolved by the round-robin rule of REQ-021; rr_ptr updates identically.
REQ-023 inflight SHALL increment on each load (REQ-018) and decrement on done_valid; both in one cycle -> unchanged.
REQ-024 done_valid with inflight==0 and no load in that cycle SHALL leave inflight at 0 and set err_underflow, which holds until reset.
REQ-025 inflight==MAX_OUTSTANDING SHALL block loads; a done_valid in that cycle does not unblock until the following cycle.
REQ-026 Per-source order SHALL be preserved; no request is dropped or duplicated.

Reset
REQ-027 Asserting rst at any time SHALL immediately clear m_valid, all m_* and m_src to 0, empty all FIFOs, and zero rr_ptr, inflight and err_underflow; in_ready becomes 1 for all sources.
REQ-028 Requests in flight inside the block when rst asserts SHALL be discarded; operation resumes on the first edge after rst deasserts.

Verification
REQ-029 Single request: src0 addr 0x100, m_ready=1 -> m_valid high 2 cycles after accept, m_addr=0x100, m_src=0, inflight=1.
REQ-030 QOS_MODE=0, both sources hold 3 requests, m_ready=1 -> m_src sequence 0,1,0,1,0,1 on consecutive cycles.
REQ-031 QOS_MODE=1, src0 qos=2 and src1 qos=9 -> src1 issued first; equal qos -> round-robin order.
REQ-032 MAX_OUTSTANDING=2, no done_valid, 4 queued -> exactly 2 issued, inflight=2; one done_valid pulse -> third request issued the next cycle.
REQ-033 Fill src0 with FIFO_DEPTH entries while m_ready=0 -> in_ready[0]=0 and m_* stable; release m_ready -> all entries emerge in order.
REQ-034 done_valid at inflight=0 -> err_underflow=1 and inflight stays 0; rst asserted mid-burst -> all outputs 0 at once.

Source files
------------

// File: rtl/outgoing_ar_arb_buffer.sv
// Per-source AR request FIFOs feeding one registered AR master port, with
// round-robin or QoS-first arbitration and a cap on issued-but-uncompleted bursts.
module outgoing_ar_arb_buffer #(
    parameter int NUM_SRC         = 2,
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 8,
    parameter int TAG_WIDTH       = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int QOS_MODE        = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_SRC-1:0]                  in_valid,
    output logic [NUM_SRC-1:0]                  in_ready,
    input  logic [NUM_SRC*ID_WIDTH-1:0]         in_id,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]       in_addr,
    input  logic [NUM_SRC*LEN_WIDTH-1:0]        in_len,
    input  logic [NUM_SRC*3-1:0]                in_size,
    input  logic [NUM_SRC*2-1:0]                in_burst,
    input  logic [NUM_SRC*4-1:0]                in_qos,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]        in_tagid,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [ID_WIDTH-1:0]                 m_id,
    output logic [ADDR_WIDTH-1:0]               m_addr,
    output logic [LEN_WIDTH-1:0]                m_len,
    output logic [2:0]                          m_size,
    output logic [1:0]                          m_burst,
    output logic [3:0]                          m_qos,
    output logic [TAG_WIDTH-1:0]                m_tagid,
    output logic [$clog2(NUM_SRC)-1:0]          m_src,
    input  logic                                done_valid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] inflight,
    output logic                                err_underflow
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [3:0]            qos;
        logic [TAG_WIDTH-1:0]  tagid;
    } req_t;

    req_t               w_head [NUM_SRC];
    logic [NUM_SRC-1:0] w_nonempty;
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic               w_load;
    logic               w_found;
    logic [SRC_W-1:0]   w_win;
    logic [SRC_W-1:0]   w_rr_next;
    logic [3:0]         w_best_qos;

    logic               r_m_valid;
    req_t               r_m_req;
    logic [SRC_W-1:0]   r_m_src;
    logic [SRC_W-1:0]   r_rr_ptr;
    logic [INF_W-1:0]   r_inflight;
    logic               r_err_underflow;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        req_t             r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0] r_wptr;
        logic [PTR_W-1:0] r_rptr;
        logic [CNT_W-1:0] r_count;
        req_t             w_in_req;

        assign w_in_req = {in_id[g*ID_WIDTH +: ID_WIDTH], in_addr[g*ADDR_WIDTH +: ADDR_WIDTH],
                           in_len[g*LEN_WIDTH +: LEN_WIDTH], in_size[g*3 +: 3],
                           in_burst[g*2 +: 2], in_qos[g*4 +: 4], in_tagid[g*TAG_WIDTH +: TAG_WIDTH]};

        assign in_ready[g]   = (r_count != CNT_W'(FIFO_DEPTH));
        assign w_nonempty[g] = (r_count != '0);
        assign w_push[g]     = in_valid[g] & in_ready[g];
        assign w_pop[g]      = w_load & (w_win == SRC_W'(g));
        assign w_head[g]     = r_mem[r_rptr];

        // NOTE: the storage array is deliberately not reset; only the pointers and
        // count decide which entries are live, so clearing those empties the FIFO.
        always_ff @(posedge clk) begin
            if (w_push[g]) begin
                r_mem[r_wptr] <= w_in_req;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push[g]) r_wptr <= r_wptr + PTR_W'(1);
                if (w_pop[g])  r_rptr <= r_rptr + PTR_W'(1);
                if (w_push[g] && !w_pop[g])      r_count <= r_count + CNT_W'(1);
                else if (!w_push[g] && w_pop[g]) r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Scan sources in round-robin order from r_rr_ptr; in QoS mode a later source
    // only wins with strictly higher QoS, so ties fall back to round-robin order.
    always_comb begin
        int               v_idx;
        logic [SRC_W-1:0] v_sel;
        w_found    = 1'b0;
        w_win      = '0;
        w_best_qos = '0;
        v_idx      = 0;
        v_sel      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_SRC) v_idx = v_idx - NUM_SRC;
            v_sel = SRC_W'(v_idx);
            if (w_nonempty[v_sel] &&
                (!w_found || (QOS_MODE == 1 && w_head[v_sel].qos > w_best_qos))) begin
                w_found    = 1'b1;
                w_win      = v_sel;
                w_best_qos = w_head[v_sel].qos;
            end
        end
    end

    assign w_rr_next = (w_win == SRC_W'(NUM_SRC - 1)) ? '0 : w_win + SRC_W'(1);
    assign w_load    = (~r_m_valid | m_ready) & w_found &
                       (r_inflight < INF_W'(MAX_OUTSTANDING));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_req   <= '0;
            r_m_src   <= '0;
            r_rr_ptr  <= '0;
        end else if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_req   <= w_head[w_win];
            r_m_src   <= w_win;
            r_rr_ptr  <= w_rr_next;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    // A completion with nothing outstanding is flagged rather than wrapping the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight      <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            case ({w_load, done_valid})
                2'b10: r_inflight <= r_inflight + INF_W'(1);
                2'b01: begin
                    if (r_inflight == '0) r_err_underflow <= 1'b1;
                    else                  r_inflight      <= r_inflight - INF_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign m_valid       = r_m_valid;
    assign m_id          = r_m_req.id;
    assign m_addr        = r_m_req.addr;
    assign m_len         = r_m_req.len;
    assign m_size        = r_m_req.size;
    assign m_burst       = r_m_req.burst;
    assign m_qos         = r_m_req.qos;
    assign m_tagid       = r_m_req.tagid;
    assign m_src         = r_m_src;
    assign inflight      = r_inflight;
    assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_outgoing_ar_arb_buffer.sv
// Directed bench: a round-robin and a QoS-first instance share stimulus; each has
// its own expected-issue queue, checked at every AR handshake.
module tb_outgoing_ar_arb_buffer;

    localparam int NS  = 2;
    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int LW  = 8;
    localparam int TW  = 4;
    localparam int FD  = 4;
    localparam int MO  = 2;
    localparam int IFW = $clog2(MO + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NS-1:0]     in_valid;
    logic [NS*IDW-1:0] in_id;
    logic [NS*AW-1:0]  in_addr;
    logic [NS*LW-1:0]  in_len;
    logic [NS*3-1:0]   in_size;
    logic [NS*2-1:0]   in_burst;
    logic [NS*4-1:0]   in_qos;
    logic [NS*TW-1:0]  in_tagid;
    logic              m_ready;
    logic              man_done;
    logic              auto_done;
    logic              done_a;
    logic              done_b;

    logic [NS-1:0]  a_in_ready, b_in_ready;
    logic           a_m_valid, b_m_valid;
    logic [IDW-1:0] a_m_id, b_m_id;
    logic [AW-1:0]  a_m_addr, b_m_addr;
    logic [LW-1:0]  a_m_len, b_m_len;
    logic [2:0]     a_m_size, b_m_size;
    logic [1:0]     a_m_burst, b_m_burst;
    logic [3:0]     a_m_qos, b_m_qos;
    logic [TW-1:0]  a_m_tagid, b_m_tagid;
    logic           a_m_src, b_m_src;
    logic [IFW-1:0] a_inflight, b_inflight;
    logic           a_err, b_err;

    // Completion source: explicit pulses, or retire one burst per cycle while any is outstanding.
    assign done_a = man_done | (auto_done & (a_inflight != '0));
    assign done_b = man_done | (auto_done & (b_inflight != '0));

    outgoing_ar_arb_buffer #(
        .NUM_SRC(NS), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
        .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO), .QOS_MODE(0)
    ) u_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_id(in_id), .in_addr(in_addr), .in_len(in_len), .in_size(in_size),
        .in_burst(in_burst), .in_qos(in_qos), .in_tagid(in_tagid),
        .m_valid(a_m_valid), .m_ready(m_ready), .m_id(a_m_id), .m_addr(a_m_addr),
        .m_len(a_m_len), .m_size(a_m_size), .m_burst(a_m_burst), .m_qos(a_m_qos),
        .m_tagid(a_m_tagid), .m_src(a_m_src), .done_valid(done_a),
        .inflight(a_inflight), .err_underflow(a_err)
    );

    outgoing_ar_arb_buffer #(
        .NUM_SRC(NS), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
        .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO), .QOS_MODE(1)
    ) u_qos (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_id(in_id), .in_addr(in_addr), .in_len(in_len), .in_size(in_size),
        .in_burst(in_burst), .in_qos(in_qos), .in_tagid(in_tagid),
        .m_valid(b_m_valid), .m_ready(m_ready), .m_id(b_m_id), .m_addr(b_m_addr),
        .m_len(b_m_len), .m_size(b_m_size), .m_burst(b_m_burst), .m_qos(b_m_qos),
        .m_tagid(b_m_tagid), .m_src(b_m_src), .done_valid(done_b),
        .inflight(b_inflight), .err_underflow(b_err)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Request fields are derived from the address so every field is distinguishable.
    function automatic logic [63:0] pack(input logic src, input logic [31:0] addr, input logic [3:0] qos);
        return 64'({src, addr[7:4], addr, addr[11:4], 3'd3, 2'b01, qos, ~addr[7:4]});
    endfunction

    function automatic logic [63:0] obs_a();
        return 64'({a_m_src, a_m_id, a_m_addr, a_m_len, a_m_size, a_m_burst, a_m_qos, a_m_tagid});
    endfunction

    function automatic logic [63:0] obs_b();
        return 64'({b_m_src, b_m_id, b_m_addr, b_m_len, b_m_size, b_m_burst, b_m_qos, b_m_tagid});
    endfunction

    // One cycle: score any handshake due at the coming edge, then return 1 after it.
    task automatic step();
        @(negedge clk);
        if (!rst && m_ready) begin
            if (a_m_valid) begin
                check("rr_sb_nonempty", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) check("rr_issue", obs_a(), qa.pop_front());
            end
            if (b_m_valid) begin
                check("qos_sb_nonempty", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0) check("qos_issue", obs_b(), qb.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [1:0] mask, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [3:0] q0, input logic [3:0] q1);
        in_valid = mask;
        in_addr  = {a1, a0};
        in_qos   = {q1, q0};
        in_id    = {a1[7:4], a0[7:4]};
        in_tagid = {~a1[7:4], ~a0[7:4]};
        in_len   = {a1[11:4], a0[11:4]};
        in_size  = {3'd3, 3'd3};
        in_burst = {2'b01, 2'b01};
        step();
        in_valid = '0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        m_ready   = 1'b0;
        man_done  = 1'b0;
        auto_done = 1'b0;
        in_valid  = '0;
        qa.delete();
        qb.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && (qa.size() != 0 || qb.size() != 0); i++) step();
        check("drain_remaining", 64'(qa.size() + qb.size()), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rr_m"}, obs_a(), 64'd0);
        check({tag, "_qos_m"}, obs_b(), 64'd0);
        check({tag, "_rr_state"}, 64'({a_m_valid, a_inflight, a_err, a_in_ready}), 64'({1'b0, 2'd0, 1'b0, 2'b11}));
        check({tag, "_qos_state"}, 64'({b_m_valid, b_inflight, b_err, b_in_ready}), 64'({1'b0, 2'd0, 1'b0, 2'b11}));
    endtask

    initial begin
        rst = 1'b1; m_ready = 1'b0; man_done = 1'b0; auto_done = 1'b0;
        in_valid = '0; in_id = '0; in_addr = '0; in_len = '0;
        in_size = '0; in_burst = '0; in_qos = '0; in_tagid = '0;
        step();
        check_reset_state("reset");
        rst = 1'b0;

        // Single request: not visible right after accept, issued one edge later.
        m_ready = 1'b1;
        qa.push_back(pack(1'b0, 32'h100, 4'd0));
        qb.push_back(pack(1'b0, 32'h100, 4'd0));
        accept(2'b01, 32'h100, 32'h0, 4'd0, 4'd0);
        check("single_no_bypass", 64'({a_m_valid, b_m_valid}), 64'd0);
        step();
        check("single_rr", 64'({a_m_valid, a_m_addr, a_m_src, a_inflight}), 64'({1'b1, 32'h100, 1'b0, 2'd1}));
        check("single_qos", 64'({b_m_valid, b_m_addr, b_m_src, b_inflight}), 64'({1'b1, 32'h100, 1'b0, 2'd1}));
        step();
        check("single_cleared", 64'({a_m_valid, b_m_valid, a_inflight, b_inflight}), 64'({2'b00, 2'd1, 2'd1}));
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        check("single_retired", 64'({a_inflight, b_inflight, a_err, b_err}), 64'd0);

        // Three requests per source, equal QoS: alternating sources on consecutive cycles.
        do_reset();
        auto_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 2; s++) begin
                qa.push_back(pack(s[0], 32'h200 + 32'(s * 16 + i * 32), 4'd5));
                qb.push_back(pack(s[0], 32'h200 + 32'(s * 16 + i * 32), 4'd5));
            end
            accept(2'b11, 32'h200 + 32'(i * 32), 32'h210 + 32'(i * 32), 4'd5, 4'd5);
        end
        m_ready = 1'b1;
        repeat (6) step();
        check("rr_back_to_back", 64'(qa.size() + qb.size()), 64'd0);
        check("rr_idle_after", 64'({a_m_valid, b_m_valid}), 64'd0);
        repeat (2) step();

        // QoS: higher QoS wins in mode 1; equal QoS falls back to round-robin.
        do_reset();
        auto_done = 1'b1;
        m_ready   = 1'b1;
        qa.push_back(pack(1'b0, 32'h300, 4'd2));
        qa.push_back(pack(1'b1, 32'h310, 4'd9));
        qb.push_back(pack(1'b1, 32'h310, 4'd9));
        qb.push_back(pack(1'b0, 32'h300, 4'd2));
        accept(2'b11, 32'h300, 32'h310, 4'd2, 4'd9);
        wait_drain(20);
        qa.push_back(pack(1'b0, 32'h320, 4'd4));
        qa.push_back(pack(1'b1, 32'h330, 4'd4));
        qb.push_back(pack(1'b1, 32'h330, 4'd4));
        qb.push_back(pack(1'b0, 32'h320, 4'd4));
        accept(2'b11, 32'h320, 32'h330, 4'd4, 4'd4);
        wait_drain(20);
        repeat (3) step();

        // Outstanding limit of 2: the third request waits for a completion.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            qa.push_back(pack(i[0], 32'h400 + 32'(i * 16), 4'd0));
            qb.push_back(pack(i[0], 32'h400 + 32'(i * 16), 4'd0));
        end
        accept(2'b11, 32'h400, 32'h410, 4'd0, 4'd0);
        accept(2'b11, 32'h420, 32'h430, 4'd0, 4'd0);
        repeat (4) step();
        check("limit_inflight", 64'({a_inflight, b_inflight, a_m_valid, b_m_valid}), 64'({2'd2, 2'd2, 2'b00}));
        check("limit_pending", 64'({qa.size(), qb.size()}), 64'({32'd2, 32'd2}));
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        check("limit_done_same_cycle", 64'({a_m_valid, b_m_valid, a_inflight, b_inflight}), 64'({2'b00, 2'd1, 2'd1}));
        step();
        check("limit_third_rr", 64'({a_m_valid, a_m_addr, a_inflight}), 64'({1'b1, 32'h420, 2'd2}));
        check("limit_third_qos", 64'({b_m_valid, b_m_addr, b_inflight}), 64'({1'b1, 32'h420, 2'd2}));
        auto_done = 1'b1;
        wait_drain(20);
        repeat (4) step();
        auto_done = 1'b0;
        check("limit_final", 64'({a_inflight, b_inflight, a_err, b_err}), 64'd0);

        // Fill source 0 under backpressure, then release and drain in order.
        do_reset();
        for (int i = 0; i < FD + 1; i++) begin
            qa.push_back(pack(1'b0, 32'h500 + 32'(i * 16), 4'd1));
            qb.push_back(pack(1'b0, 32'h500 + 32'(i * 16), 4'd1));
            accept(2'b01, 32'h500 + 32'(i * 16), 32'h0, 4'd1, 4'd0);
        end
        check("full_in_ready", 64'({a_in_ready, b_in_ready}), 64'(4'b1010));
        check("full_hold_rr", 64'({a_m_valid, a_m_addr, a_m_src}), 64'({1'b1, 32'h500, 1'b0}));
        in_valid = 2'b01;
        in_addr  = {32'h0, 32'h5F0};
        step();
        step();
        in_valid = '0;
        check("full_stable_rr", obs_a(), pack(1'b0, 32'h500, 4'd1));
        check("full_stable_qos", obs_b(), pack(1'b0, 32'h500, 4'd1));
        check("full_still_full", 64'({a_in_ready, b_in_ready}), 64'(4'b1010));
        m_ready   = 1'b1;
        auto_done = 1'b1;
        wait_drain(40);
        repeat (4) step();
        auto_done = 1'b0;
        check("full_final", 64'({a_inflight, b_inflight, a_m_valid, b_m_valid}), 64'd0);

        // Underflow is sticky; an asynchronous reset mid-burst clears everything at once.
        do_reset();
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        check("underflow_set", 64'({a_err, b_err, a_inflight, b_inflight}), 64'({2'b11, 2'd0, 2'd0}));
        repeat (2) step();
        check("underflow_sticky", 64'({a_err, b_err}), 64'(2'b11));
        m_ready = 1'b1;
        accept(2'b11, 32'h600, 32'h610, 4'd0, 4'd0);
        step();
        check("midburst_active", 64'({a_m_valid, a_m_addr, b_m_valid, b_m_addr}), 64'({1'b1, 32'h600, 1'b1, 32'h600}));
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_reset");
        step();
        step();
        rst = 1'b0;
        repeat (4) step();
        check("discarded", 64'({a_m_valid, b_m_valid, a_inflight, b_inflight}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
